// File: rtl/rf_access_sched.sv
// rf_access_sched: operand-read gating and write-back scheduling for the
// TPU backend RegFile.
//   Issue side : I_Issue_* request/operands/destination -> O_Issue_Ack,
//                O_Stall, O_RF_Re1/2 (combinational, busy-scoreboard gated)
//   Write-back : two sources (WB0 = ALU, WB1 = MAU), one skid entry each,
//                O_WBn_Ack = skid free or being drained this cycle
//   RegFile    : O_RF_We/O_RF_Dst_Idx/O_RF_Data registered, one write/cycle
//   Status     : O_WB_Err (sticky, write to non-busy reg), O_Idle
module rf_access_sched #(
  parameter int unsigned NUM_REGS = 64,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              I_Issue_Req,
  input  logic              I_Issue_Src1_V,
  input  logic [IDX_W-1:0]  I_Issue_Src1_Idx,
  input  logic              I_Issue_Src2_V,
  input  logic [IDX_W-1:0]  I_Issue_Src2_Idx,
  input  logic              I_Issue_Dst_V,
  input  logic [IDX_W-1:0]  I_Issue_Dst_Idx,
  output logic              O_Issue_Ack,
  output logic              O_Stall,
  output logic              O_RF_Re1,
  output logic              O_RF_Re2,
  input  logic              I_WB0_Req,
  input  logic [IDX_W-1:0]  I_WB0_Idx,
  input  logic [DATA_W-1:0] I_WB0_Data,
  input  logic              I_WB1_Req,
  input  logic [IDX_W-1:0]  I_WB1_Idx,
  input  logic [DATA_W-1:0] I_WB1_Data,
  output logic              O_WB0_Ack,
  output logic              O_WB1_Ack,
  output logic              O_RF_We,
  output logic [IDX_W-1:0]  O_RF_Dst_Idx,
  output logic [DATA_W-1:0] O_RF_Data,
  output logic              O_WB_Err,
  output logic              O_Idle
);

  typedef enum logic {RR_WB0 = 1'b0, RR_WB1 = 1'b1} rr_e;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                full0_q, full0_d, full1_q, full1_d;
  logic [IDX_W-1:0]    sk0_idx_q, sk0_idx_d, sk1_idx_q, sk1_idx_d;
  logic [DATA_W-1:0]   sk0_data_q, sk0_data_d, sk1_data_q, sk1_data_d;
  rr_e                 rr_q, rr_d;
  logic                we_q, we_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic                idle_q, idle_d;

  logic hz, issue_ack, grant0, grant1, wb0_ack, wb1_ack;

  always_comb begin
    hz = (I_Issue_Src1_V & busy_q[I_Issue_Src1_Idx])
       | (I_Issue_Src2_V & busy_q[I_Issue_Src2_Idx])
       | (I_Issue_Dst_V  & busy_q[I_Issue_Dst_Idx]);
    issue_ack = I_Issue_Req & ~hz;
    grant0 = full0_q & (~full1_q | (rr_q == RR_WB0));
    grant1 = full1_q & (~full0_q | (rr_q == RR_WB1));
    wb0_ack = ~full0_q | grant0;
    wb1_ack = ~full1_q | grant1;
  end

  assign O_Issue_Ack  = issue_ack;
  assign O_Stall      = I_Issue_Req & ~issue_ack;
  assign O_RF_Re1     = issue_ack & I_Issue_Src1_V;
  assign O_RF_Re2     = issue_ack & I_Issue_Src2_V;
  assign O_WB0_Ack    = wb0_ack;
  assign O_WB1_Ack    = wb1_ack;
  assign O_RF_We      = we_q;
  assign O_RF_Dst_Idx = idx_q;
  assign O_RF_Data    = data_q;
  assign O_WB_Err     = err_q;
  assign O_Idle       = idle_q;

  always_comb begin
    // Clear at the RegFile write edge, then set, so a same-edge set wins.
    busy_d = busy_q;
    if (we_q) busy_d[idx_q] = 1'b0;
    if (issue_ack & I_Issue_Dst_V) busy_d[I_Issue_Dst_Idx] = 1'b1;
    err_d = err_q | (we_q & ~busy_q[idx_q]);

    // A skid drained this cycle may be refilled on the same edge.
    full0_d    = full0_q & ~grant0;
    sk0_idx_d  = sk0_idx_q;
    sk0_data_d = sk0_data_q;
    if (I_WB0_Req & wb0_ack) begin
      full0_d    = 1'b1;
      sk0_idx_d  = I_WB0_Idx;
      sk0_data_d = I_WB0_Data;
    end
    full1_d    = full1_q & ~grant1;
    sk1_idx_d  = sk1_idx_q;
    sk1_data_d = sk1_data_q;
    if (I_WB1_Req & wb1_ack) begin
      full1_d    = 1'b1;
      sk1_idx_d  = I_WB1_Idx;
      sk1_data_d = I_WB1_Data;
    end

    // Only contested grants move the pointer, always to the loser.
    rr_d = rr_q;
    if (full0_q & full1_q) rr_d = grant0 ? RR_WB1 : RR_WB0;

    we_d   = grant0 | grant1;
    idx_d  = idx_q;
    data_d = data_q;
    if (grant0) begin
      idx_d  = sk0_idx_q;
      data_d = sk0_data_q;
    end else if (grant1) begin
      idx_d  = sk1_idx_q;
      data_d = sk1_data_q;
    end

    idle_d = (busy_d == '0) & ~full0_d & ~full1_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      full0_q    <= 1'b0;
      full1_q    <= 1'b0;
      sk0_idx_q  <= '0;
      sk0_data_q <= '0;
      sk1_idx_q  <= '0;
      sk1_data_q <= '0;
      rr_q       <= RR_WB0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      busy_q     <= busy_d;
      full0_q    <= full0_d;
      full1_q    <= full1_d;
      sk0_idx_q  <= sk0_idx_d;
      sk0_data_q <= sk0_data_d;
      sk1_idx_q  <= sk1_idx_d;
      sk1_data_q <= sk1_data_d;
      rr_q       <= rr_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      err_q      <= err_d;
      idle_q     <= idle_d;
    end
  end

endmodule

// File: tb/tb_rf_access_sched.sv
// Self-checking bench for rf_access_sched: directed scenarios plus a
// randomized run against a behavioural scoreboard/skid model.
module tb_rf_access_sched;
  localparam int NR = 64;
  localparam int IW = 6;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          I_Issue_Req, I_Issue_Src1_V, I_Issue_Src2_V, I_Issue_Dst_V;
  logic [IW-1:0] I_Issue_Src1_Idx, I_Issue_Src2_Idx, I_Issue_Dst_Idx;
  logic          O_Issue_Ack, O_Stall, O_RF_Re1, O_RF_Re2;
  logic          I_WB0_Req, I_WB1_Req;
  logic [IW-1:0] I_WB0_Idx, I_WB1_Idx;
  logic [DW-1:0] I_WB0_Data, I_WB1_Data;
  logic          O_WB0_Ack, O_WB1_Ack, O_RF_We, O_WB_Err, O_Idle;
  logic [IW-1:0] O_RF_Dst_Idx;
  logic [DW-1:0] O_RF_Data;

  always #5 clock = ~clock;

  rf_access_sched #(.NUM_REGS(NR), .IDX_W(IW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .I_Issue_Req(I_Issue_Req),
    .I_Issue_Src1_V(I_Issue_Src1_V), .I_Issue_Src1_Idx(I_Issue_Src1_Idx),
    .I_Issue_Src2_V(I_Issue_Src2_V), .I_Issue_Src2_Idx(I_Issue_Src2_Idx),
    .I_Issue_Dst_V(I_Issue_Dst_V), .I_Issue_Dst_Idx(I_Issue_Dst_Idx),
    .O_Issue_Ack(O_Issue_Ack), .O_Stall(O_Stall),
    .O_RF_Re1(O_RF_Re1), .O_RF_Re2(O_RF_Re2),
    .I_WB0_Req(I_WB0_Req), .I_WB0_Idx(I_WB0_Idx), .I_WB0_Data(I_WB0_Data),
    .I_WB1_Req(I_WB1_Req), .I_WB1_Idx(I_WB1_Idx), .I_WB1_Data(I_WB1_Data),
    .O_WB0_Ack(O_WB0_Ack), .O_WB1_Ack(O_WB1_Ack),
    .O_RF_We(O_RF_We), .O_RF_Dst_Idx(O_RF_Dst_Idx), .O_RF_Data(O_RF_Data),
    .O_WB_Err(O_WB_Err), .O_Idle(O_Idle)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: scoreboard array, skid slots, commit register.
  bit            m_busy[NR];
  bit            m_full[2];
  logic [IW-1:0] m_sidx[2];
  logic [DW-1:0] m_sdata[2];
  int            m_rr;
  bit            m_we, m_err, m_idle;
  logic [IW-1:0] m_idx;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_full[0] = 1'b0; m_full[1] = 1'b0;
    m_rr = 0; m_we = 1'b0; m_err = 1'b0; m_idle = 1'b1;
    m_idx = '0; m_data = '0;
  endtask

  function automatic bit exp_ack();
    bit hz;
    hz = (I_Issue_Src1_V && m_busy[I_Issue_Src1_Idx]) ||
         (I_Issue_Src2_V && m_busy[I_Issue_Src2_Idx]) ||
         (I_Issue_Dst_V  && m_busy[I_Issue_Dst_Idx]);
    return I_Issue_Req && !hz;
  endfunction

  function automatic int exp_grant();
    if (m_full[0] && m_full[1]) return m_rr;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic bit exp_wback(int s);
    return !m_full[s] || (exp_grant() == s);
  endfunction

  task automatic model_step();
    int g;
    bit acc[2];
    bit nb[NR];
    g = exp_grant();
    acc[0] = I_WB0_Req && exp_wback(0);
    acc[1] = I_WB1_Req && exp_wback(1);
    nb = m_busy;
    if (m_we) begin
      if (!m_busy[m_idx]) m_err = 1'b1;
      nb[m_idx] = 1'b0;
    end
    if (exp_ack() && I_Issue_Dst_V) nb[I_Issue_Dst_Idx] = 1'b1;
    if (m_full[0] && m_full[1]) m_rr = 1 - g;
    m_we = (g >= 0);
    if (g >= 0) begin
      m_idx = m_sidx[g];
      m_data = m_sdata[g];
      m_full[g] = 1'b0;
    end
    if (acc[0]) begin m_full[0] = 1'b1; m_sidx[0] = I_WB0_Idx; m_sdata[0] = I_WB0_Data; end
    if (acc[1]) begin m_full[1] = 1'b1; m_sidx[1] = I_WB1_Idx; m_sdata[1] = I_WB1_Data; end
    m_busy = nb;
    m_idle = !m_full[0] && !m_full[1];
    foreach (nb[i]) if (nb[i]) m_idle = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    I_Issue_Req = 0; I_Issue_Src1_V = 0; I_Issue_Src2_V = 0; I_Issue_Dst_V = 0;
    I_Issue_Src1_Idx = '0; I_Issue_Src2_Idx = '0; I_Issue_Dst_Idx = '0;
    I_WB0_Req = 0; I_WB0_Idx = '0; I_WB0_Data = '0;
    I_WB1_Req = 0; I_WB1_Idx = '0; I_WB1_Data = '0;
  endtask

  task automatic set_issue(bit s1v, int s1, bit s2v, int s2, bit dv, int d);
    I_Issue_Req = 1;
    I_Issue_Src1_V = s1v; I_Issue_Src1_Idx = IW'(s1);
    I_Issue_Src2_V = s2v; I_Issue_Src2_Idx = IW'(s2);
    I_Issue_Dst_V = dv;   I_Issue_Dst_Idx = IW'(d);
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1;
    model_reset();
    @(posedge clock);
    #1 reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_total++; if (O_RF_We !== 1'b0) $display("FAIL reset_we: got %b exp 0", O_RF_We); else n_pass++;
    n_total++; if (O_RF_Dst_Idx !== '0) $display("FAIL reset_idx: got %0d exp 0", O_RF_Dst_Idx); else n_pass++;
    n_total++; if (O_RF_Data !== '0) $display("FAIL reset_data: got %h exp 0", O_RF_Data); else n_pass++;
    n_total++; if (O_WB_Err !== 1'b0) $display("FAIL reset_err: got %b exp 0", O_WB_Err); else n_pass++;
    n_total++; if (O_Idle !== 1'b1) $display("FAIL reset_idle: got %b exp 1", O_Idle); else n_pass++;
    n_total++; if ({O_WB0_Ack, O_WB1_Ack} !== 2'b11) $display("FAIL reset_wback: got %b exp 11", {O_WB0_Ack, O_WB1_Ack}); else n_pass++;
  endtask

  task automatic test_issue_basic();
    set_issue(1, 3, 1, 5, 1, 7);
    #1;
    n_total++; if ({O_Issue_Ack, O_RF_Re1, O_RF_Re2, O_Stall} !== 4'b1110) $display("FAIL issue_ack_re: got %b exp 1110", {O_Issue_Ack, O_RF_Re1, O_RF_Re2, O_Stall}); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_total++; if (O_Idle !== 1'b0) $display("FAIL issue_idle: got %b exp 0", O_Idle); else n_pass++;
  endtask

  task automatic test_raw_wb();
    set_issue(1, 7, 0, 0, 0, 0);
    I_WB0_Req = 1; I_WB0_Idx = 7; I_WB0_Data = 32'hDEADBEEF;
    #1;
    n_total++; if (O_Stall !== 1'b1) $display("FAIL raw_stall_c0: got %b exp 1", O_Stall); else n_pass++;
    n_total++; if (O_WB0_Ack !== 1'b1) $display("FAIL raw_wback_c0: got %b exp 1", O_WB0_Ack); else n_pass++;
    tick();
    I_WB0_Req = 0;
    #1;
    n_total++; if (O_Stall !== 1'b1) $display("FAIL raw_stall_c1: got %b exp 1", O_Stall); else n_pass++;
    tick();
    n_total++; if (O_Stall !== 1'b1) $display("FAIL raw_stall_c2: got %b exp 1", O_Stall); else n_pass++;
    n_total++; if ({O_RF_We, O_RF_Dst_Idx, O_RF_Data} !== {1'b1, 6'd7, 32'hDEADBEEF})
      $display("FAIL raw_commit: got we=%b idx=%0d data=%h exp we=1 idx=7 data=deadbeef", O_RF_We, O_RF_Dst_Idx, O_RF_Data); else n_pass++;
    tick();
    n_total++; if ({O_Issue_Ack, O_RF_Re1} !== 2'b11) $display("FAIL raw_ack_c3: got %b exp 11", {O_Issue_Ack, O_RF_Re1}); else n_pass++;
    n_total++; if (O_RF_We !== 1'b0) $display("FAIL raw_we_drop: got %b exp 0", O_RF_We); else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_waw();
    set_issue(0, 0, 0, 0, 1, 4);
    tick();
    n_total++; if (O_Issue_Ack !== 1'b0) $display("FAIL waw_ack: got %b exp 0", O_Issue_Ack); else n_pass++;
    I_Issue_Dst_V = 0;
    #1;
    n_total++; if (O_Issue_Ack !== 1'b1) $display("FAIL waw_nodst_ack: got %b exp 1", O_Issue_Ack); else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    apply_reset();
    set_issue(0, 0, 0, 0, 1, 1);
    tick();
    set_issue(0, 0, 0, 0, 1, 2);
    tick();
    clear_inputs();
    I_WB0_Req = 1; I_WB0_Idx = 1; I_WB0_Data = 32'h100;
    I_WB1_Req = 1; I_WB1_Idx = 2; I_WB1_Data = 32'h200;
    #1;
    n_total++; if ({O_WB0_Ack, O_WB1_Ack} !== 2'b11) $display("FAIL rr_fill_ack: got %b exp 11", {O_WB0_Ack, O_WB1_Ack}); else n_pass++;
    tick();
    n_total++; if ({O_WB0_Ack, O_WB1_Ack} !== 2'b10) $display("FAIL rr_first_ack: got %b exp 10", {O_WB0_Ack, O_WB1_Ack}); else n_pass++;
    tick();
    for (int k = 0; k < 6; k++) begin
      n_total++;
      if ({O_RF_We, O_RF_Dst_Idx, O_RF_Data} !== {1'b1, (k % 2 == 0) ? 6'd1 : 6'd2, (k % 2 == 0) ? 32'h100 : 32'h200})
        $display("FAIL rr_commit_%0d: got we=%b idx=%0d data=%h", k, O_RF_We, O_RF_Dst_Idx, O_RF_Data);
      else n_pass++;
      n_total++;
      if ({O_WB0_Ack, O_WB1_Ack} !== ((k % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL rr_ack_%0d: got %b exp %b", k, {O_WB0_Ack, O_WB1_Ack}, (k % 2 == 0) ? 2'b01 : 2'b10);
      else n_pass++;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_wb_err();
    apply_reset();
    I_WB1_Req = 1; I_WB1_Idx = 9; I_WB1_Data = 32'h99;
    tick();
    clear_inputs();
    tick();
    n_total++; if ({O_RF_We, O_RF_Dst_Idx, O_RF_Data} !== {1'b1, 6'd9, 32'h99})
      $display("FAIL err_commit: got we=%b idx=%0d data=%h exp 1/9/99", O_RF_We, O_RF_Dst_Idx, O_RF_Data); else n_pass++;
    n_total++; if (O_WB_Err !== 1'b0) $display("FAIL err_early: got %b exp 0", O_WB_Err); else n_pass++;
    tick();
    for (int k = 0; k < 20; k++) begin
      n_total++; if (O_WB_Err !== 1'b1) $display("FAIL err_sticky_%0d: got %b exp 1", k, O_WB_Err); else n_pass++;
      tick();
    end
    apply_reset();
    n_total++; if (O_WB_Err !== 1'b0) $display("FAIL err_cleared: got %b exp 0", O_WB_Err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_issue(0, 0, 0, 0, 1, 2);
    I_WB0_Req = 1; I_WB0_Idx = 2; I_WB0_Data = 32'h22;
    I_WB1_Req = 1; I_WB1_Idx = 3; I_WB1_Data = 32'h33;
    tick();
    clear_inputs();
    #2 reset = 1;
    #1;
    model_reset();
    n_total++; if ({O_RF_We, O_WB_Err, O_Idle} !== 3'b001) $display("FAIL midrst_async: got %b exp 001", {O_RF_We, O_WB_Err, O_Idle}); else n_pass++;
    @(posedge clock);
    #1 reset = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_total++; if ({O_RF_We, O_WB_Err, O_Idle} !== 3'b001) $display("FAIL midrst_after_%0d: got %b exp 001", k, {O_RF_We, O_WB_Err, O_Idle}); else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      I_Issue_Req = ($urandom_range(0, 3) != 0);
      I_Issue_Src1_V = $urandom_range(0, 1); I_Issue_Src1_Idx = IW'($urandom_range(0, 7));
      I_Issue_Src2_V = $urandom_range(0, 1); I_Issue_Src2_Idx = IW'($urandom_range(0, 7));
      I_Issue_Dst_V = $urandom_range(0, 1);  I_Issue_Dst_Idx = IW'($urandom_range(0, 7));
      I_WB0_Req = $urandom_range(0, 1); I_WB0_Idx = IW'($urandom_range(0, 7)); I_WB0_Data = $urandom;
      I_WB1_Req = $urandom_range(0, 1); I_WB1_Idx = IW'($urandom_range(0, 7)); I_WB1_Data = $urandom;
      #1;
      n_total++;
      if ({O_Issue_Ack, O_Stall, O_RF_Re1, O_RF_Re2} !==
          {exp_ack(), I_Issue_Req && !exp_ack(), exp_ack() && I_Issue_Src1_V, exp_ack() && I_Issue_Src2_V})
        $display("FAIL rnd_issue_%0d: got %b exp %b", c, {O_Issue_Ack, O_Stall, O_RF_Re1, O_RF_Re2},
                 {exp_ack(), I_Issue_Req && !exp_ack(), exp_ack() && I_Issue_Src1_V, exp_ack() && I_Issue_Src2_V});
      else n_pass++;
      n_total++;
      if ({O_WB0_Ack, O_WB1_Ack} !== {exp_wback(0), exp_wback(1)})
        $display("FAIL rnd_wback_%0d: got %b exp %b", c, {O_WB0_Ack, O_WB1_Ack}, {exp_wback(0), exp_wback(1)});
      else n_pass++;
      tick();
      n_total++;
      if ({O_RF_We, O_RF_Dst_Idx, O_RF_Data, O_WB_Err, O_Idle} !== {m_we, m_idx, m_data, m_err, m_idle})
        $display("FAIL rnd_reg_%0d: got we=%b idx=%0d data=%h err=%b idle=%b exp we=%b idx=%0d data=%h err=%b idle=%b",
                 c, O_RF_We, O_RF_Dst_Idx, O_RF_Data, O_WB_Err, O_Idle, m_we, m_idx, m_data, m_err, m_idle);
      else n_pass++;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_issue_basic();
    test_raw_wb();
    test_waw();
    test_round_robin();
    test_wb_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_access_sched.md
Name: rf_access_sched

Overview:
- Scheduler and hazard controller in front of the TPU backend RegFile.
- Gates operand-read requests from the Index stage with a per-register busy scoreboard (RAW/WAW).
- Shares the single RegFile write port between two write-back sources (ALU pipe, MAU pipe) using one skid entry per source and round-robin arbitration.

Parameters:
NUM_REGS, 64, number of architectural registers tracked
IDX_W, 6, register index width, equal to log2(NUM_REGS)
DATA_W, 32, write-back data width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
I_Issue_Req  in  1  Index stage requests operand read plus destination reservation
I_Issue_Src1_V  in  1  source-1 is a register operand
I_Issue_Src1_Idx  in  IDX_W  source-1 index
I_Issue_Src2_V  in  1  source-2 is a register operand
I_Issue_Src2_Idx  in  IDX_W  source-2 index
I_Issue_Dst_V  in  1  instruction writes a register
I_Issue_Dst_Idx  in  IDX_W  destination index
O_Issue_Ack  out  1  issue accepted this cycle
O_Stall  out  1  I_Issue_Req & ~O_Issue_Ack
O_RF_Re1  out  1  RegFile read enable, source-1
O_RF_Re2  out  1  RegFile read enable, source-2
I_WB0_Req / I_WB1_Req  in  1  write-back request, ALU / MAU
I_WB0_Idx / I_WB1_Idx  in  IDX_W  write-back index
I_WB0_Data / I_WB1_Data  in  DATA_W  write-back data
O_WB0_Ack / O_WB1_Ack  out  1  write-back accepted into skid
O_RF_We  out  1  RegFile write enable (registered)
O_RF_Dst_Idx  out  IDX_W  RegFile write index (registered)
O_RF_Data  out  DATA_W  RegFile write data (registered)
O_WB_Err  out  1  sticky: write-back hit a non-busy register
O_Idle  out  1  no busy bits and both skids empty

Behaviour:
- Reset (async, any time including mid-operation):
  - busy[] = 0; both skids empty; rr_ptr = 0.
  - O_RF_We = 0, O_RF_Dst_Idx = 0, O_RF_Data = 0, O_WB_Err = 0.
  - Pending write-backs are dropped, not replayed.
- Hazard check (combinational):
  - hz = (Src1_V & busy[Src1_Idx]) | (Src2_V & busy[Src2_Idx]) | (Dst_V & busy[Dst_Idx]).
  - O_Issue_Ack = I_Issue_Req & ~hz.
  - O_RF_Re1 = O_Issue_Ack & Src1_V; O_RF_Re2 = O_Issue_Ack & Src2_V. Zero-latency read path.
- Reservation:
  - On the edge ending a cycle where O_Issue_Ack & Dst_V, set busy[Dst_Idx].
  - Same index set and cleared on the same edge: set wins. Unreachable in legal flow, because WAW stalls.
- Skids (one entry per WBn):
  - O_WBn_Ack = ~fulln | grantn. A skid may be drained and refilled in the same cycle.
  - Req & Ack loads Idx/Data into the skid at the next edge.
- Arbitration (combinational, over full skids):
  - Only one skid full: grant it.
  - Both full: grant rr_ptr; after a both-full grant, rr_ptr flips to the loser.
  - Single-full grants do not move rr_ptr.
- Write commit:
  - A grant at cycle t registers O_RF_We=1, Idx, Data for cycle t+1.
  - O_RF_We = 0 in cycles with no grant; Idx/Data hold their last values.
  - busy[Idx] clears on the edge ending cycle t+1, i.e. the RegFile write edge.
  - A dependent read can therefore be acked at t+2 at the earliest.
- Error flag: if busy[Idx] = 0 at commit, O_WB_Err sets and stays set until reset. The write is still performed.
- Throughput:
  - One write per cycle total.
  - Each source sustains 1/cycle when uncontended; 1 per 2 cycles each when both are saturated.
  - Issue may proceed every cycle when hazard-free.
- O_Idle is registered from next-state (busy == 0) & both skids empty.

Test Plan:
- Post-reset issue Src1=3, Src2=5, Dst=7 -> Ack=1, Re1=Re2=1; busy[7]=1 next cycle; O_Idle=0.
- Issue Src1=7 while busy[7]; WB0 Idx=7, Data=0xDEADBEEF at cycle 10 -> Stall=1 through cycle 12. O_RF_We=1, Idx=7, Data=0xDEADBEEF at cycle 12. Ack=1 at cycle 13.
- WB0 (Idx=1) and WB1 (Idx=2) held asserted every cycle with both busy and skids full -> grants alternate WB0, WB1, WB0 starting at rr_ptr=0. Writes for 1 and 2 alternate on consecutive cycles. Acks toggle accordingly.
- Issue Dst=4 while busy[4]=1 (WAW) -> Ack=0. Same Dst=4 with Dst_V=0 -> Ack=1.
- WB1 Idx=9 with busy[9]=0 -> write performed; O_WB_Err=1 and held for 20 cycles until reset.
- Assert reset with busy[2]=1 and both skids full -> O_RF_We=0, O_WB_Err=0, O_Idle=1 after release; no write issued for the dropped entries.
